// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle integer divider for the MIPS DIV/DIVU instructions.
//   One restoring shift-subtract step per clock: quotient goes to lo,
//   remainder goes to hi. The quotient truncates toward zero and the
//   remainder takes the sign of the dividend.
//
//   Latency: a start accepted at edge N raises done after edge N+33. busy is
//   high for the 33 cycles in between. A zero divisor takes a single-edge
//   fast path: dz=1, lo=all ones, hi=dividend, and busy never rises.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      divide request, only looked at while IDLE
//   is_signed  1 = DIV (two's complement), 0 = DIVU
//   sr         dividend
//   tg         divisor
//   abort      (DIV_ABORT_EN only) drop the running operation
//   busy       operation in progress
//   done       one-cycle completion pulse
//   hi         remainder
//   lo         quotient
//   dz         last operation divided by zero
//
// Build option
//   DIV_ABORT_EN  adds the abort input. abort in CALC/FIX returns to IDLE with
//                 no done pulse and leaves hi/lo/dz unchanged. Undefined by
//                 default, and then every accepted operation completes.
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] tg,
`ifdef DIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  // state | meaning
  // IDLE  | waiting for start; also handles the divide-by-zero fast path
  // CALC  | WIDTH restoring shift-subtract iterations
  // FIX   | apply signs, publish hi/lo, pulse done
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;    // dividend magnitude, consumed MSB first
  logic [WIDTH-1:0] dvs;    // divisor magnitude
  logic [WIDTH-1:0] rem;    // partial remainder
  logic [WIDTH-1:0] quot;   // quotient magnitude
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] sr_mag;
  logic [WIDTH-1:0] tg_mag;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic             abort_req;

`ifdef DIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The most negative value has no positive counterpart. Its negation is
  // itself, which is still the right magnitude when read as unsigned.
  always_comb begin
    sr_mag = sr;
    tg_mag = tg;
    if (is_signed && sr[WIDTH-1]) sr_mag = -sr;
    if (is_signed && tg[WIDTH-1]) tg_mag = -tg;
  end

  // The shifted remainder keeps the bit that falls out of the top. Without
  // it, divisors of 2^(WIDTH-1) or more would give wrong results. After a
  // subtract the difference is always below the divisor, so WIDTH-bit
  // modular arithmetic is exact.
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nxt = rem_sh[WIDTH-1:0];
    if (ge) rem_nxt = rem_sh[WIDTH-1:0] - dvs;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quot  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_req && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (tg == '0) begin
                dz   <= 1'b1;
                lo   <= '1;
                hi   <= sr;
                done <= 1'b1;
              end else begin
                dvd   <= sr_mag;
                dvs   <= tg_mag;
                q_neg <= is_signed & (sr[WIDTH-1] ^ tg[WIDTH-1]);
                r_neg <= is_signed & sr[WIDTH-1];
                rem   <= '0;
                quot  <= '0;
                count <= '0;
                busy  <= 1'b1;
                state <= CALC;
              end
            end
          end

          CALC: begin
            rem   <= rem_nxt;
            dvd   <= {dvd[WIDTH-2:0], 1'b0};
            quot  <= {quot[WIDTH-2:0], ge};
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) state <= FIX;
          end

          FIX: begin
            lo    <= q_neg ? -quot : quot;
            hi    <= r_neg ? -rem : rem;
            dz    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            count <= '0;
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
